// File: rtl/vis_pkg.sv
// Shared definitions for the spectrum-bar display path.
//
// Contents:
//   NUM_BINS, IDX_W   - number of spectrum bins and the width of a bin index
//   MAG_W, HEIGHT_W   - bin magnitude width and bar height width
//   H_MAX_DEFAULT     - default bar height saturation (visible lines)
//   ingest_state_t    - bin-beat ingest FSM states
//   commit_state_t    - frame commit sequencer states
//   sat_sub()         - unsigned subtract that clamps at zero
package vis_pkg;

    localparam int NUM_BINS      = 16;
    localparam int IDX_W         = 4;
    localparam int MAG_W         = 24;
    localparam int HEIGHT_W      = 9;
    localparam int H_MAX_DEFAULT = 480;

    typedef enum logic [1:0] {
        ING_IDLE    = 2'd0,  // waiting for bin 0
        ING_COLLECT = 2'd1,  // waiting for bin exp_idx (1..15)
        ING_FULL    = 2'd2   // all 16 bins held, waiting for a commit
    } ingest_state_t;

    typedef enum logic {
        CMT_WAIT   = 1'b0,
        CMT_COMMIT = 1'b1
    } commit_state_t;

    function automatic logic [HEIGHT_W-1:0] sat_sub(input logic [HEIGHT_W-1:0] a,
                                                    input logic [HEIGHT_W-1:0] b);
        return (a >= b) ? a - b : '0;
    endfunction

endpackage

// File: rtl/bar_height_conv.sv
// Combinational magnitude-to-bar-height conversion.
//
// Negative magnitudes give height 0; otherwise the magnitude is scaled down
// by SHIFT and clamped to H_MAX.
//
// Ports:
//   mag     in   MAG_W     signed two's-complement bin magnitude
//   height  out  HEIGHT_W  bar height, 0..H_MAX
module bar_height_conv
    import vis_pkg::*;
#(
    parameter int SHIFT = 14,
    parameter int H_MAX = H_MAX_DEFAULT
) (
    input  logic [MAG_W-1:0]    mag,
    output logic [HEIGHT_W-1:0] height
);

    logic [MAG_W-1:0] scaled;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any branch, so no path can leave it unassigned and infer a latch.
        height = '0;
        scaled = mag >> SHIFT;
        if (!mag[MAG_W-1]) begin
            if (scaled > MAG_W'(H_MAX)) begin
                height = HEIGHT_W'(H_MAX);
            end else begin
                height = scaled[HEIGHT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bar_update_scheduler.sv
// Spectrum bar update scheduler.
//
// Collects 16 bin magnitudes per frame into a shadow height table, then on
// vertical blanking walks the displayed table one bin per cycle, merging the
// new heights with a per-frame decay of the old ones (peak-fall effect).
//
// Ports:
//   clk           in   1   pixel clock
//   rst           in   1   asynchronous active-high reset
//   in_valid      in   1   bin beat valid
//   in_ready      out  1   beat accepted when in_valid && in_ready
//   in_idx        in   4   bin index of the beat
//   in_mag        in   24  signed bin magnitude
//   vblank_start  in   1   one-cycle pulse at start of vertical blanking
//   rd_idx        in   4   display bin to read
//   rd_height     out  9   registered height of bin rd_idx (1-cycle latency)
//   commit_done   out  1   pulse in the cycle after the last bin is committed
//   err_seq       out  1   pulse in the cycle after an out-of-sequence beat
module bar_update_scheduler
    import vis_pkg::*;
#(
    parameter int DECAY = 4,
    parameter int SHIFT = 14,
    parameter int H_MAX = H_MAX_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IDX_W-1:0]    in_idx,
    input  logic [MAG_W-1:0]    in_mag,
    input  logic                vblank_start,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [HEIGHT_W-1:0] rd_height,
    output logic                commit_done,
    output logic                err_seq
);

    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_BINS - 1);
    localparam logic [HEIGHT_W-1:0] DECAY_H  = HEIGHT_W'(DECAY);

    ingest_state_t          ing_state, ing_next;
    logic [IDX_W-1:0]       exp_idx, exp_next;
    commit_state_t          cmt_state, cmt_next;
    logic [IDX_W-1:0]       cmt_idx;
    logic                   use_new;

    logic [HEIGHT_W-1:0]    disp   [NUM_BINS];
    logic [HEIGHT_W-1:0]    shadow [NUM_BINS];

    logic                   accept;
    logic                   shadow_we;
    logic                   seq_err;
    logic                   commit_last;
    logic                   commit_release;
    logic [HEIGHT_W-1:0]    conv_height;
    logic [HEIGHT_W-1:0]    fresh;
    logic [HEIGHT_W-1:0]    decayed;
    logic [HEIGHT_W-1:0]    merged;

    bar_height_conv #(
        .SHIFT (SHIFT),
        .H_MAX (H_MAX)
    ) u_conv (
        .mag    (in_mag),
        .height (conv_height)
    );

    assign in_ready       = (ing_state != ING_FULL);
    assign accept         = in_valid && in_ready;
    assign commit_last    = (cmt_state == CMT_COMMIT) && (cmt_idx == LAST_IDX);
    // The shadow set is handed over only when this commit actually used it.
    assign commit_release = commit_last && use_new;

    // Ingest FSM: next state and shadow write strobe.
    always_comb begin
        ing_next  = ing_state;
        exp_next  = exp_idx;
        shadow_we = 1'b0;
        seq_err   = 1'b0;
        case (ing_state)
            ING_FULL: begin
                if (commit_release) begin
                    ing_next = ING_IDLE;
                    exp_next = '0;
                end
            end
            default: begin
                if (accept) begin
                    if (in_idx == exp_idx) begin
                        shadow_we = 1'b1;
                        if (in_idx == LAST_IDX) begin
                            ing_next = ING_FULL;
                            exp_next = '0;
                        end else begin
                            ing_next = ING_COLLECT;
                            exp_next = exp_idx + 1'b1;
                        end
                    end else if (in_idx == '0) begin
                        // A fresh bin 0 restarts the frame from any point.
                        shadow_we = 1'b1;
                        ing_next  = ING_COLLECT;
                        exp_next  = IDX_W'(1);
                    end else begin
                        seq_err  = 1'b1;
                        ing_next = ING_IDLE;
                        exp_next = '0;
                    end
                end
            end
        endcase
    end

    // Commit sequencer: vblank_start arriving mid-commit is simply dropped.
    always_comb begin
        cmt_next = cmt_state;
        case (cmt_state)
            CMT_WAIT:   if (vblank_start) cmt_next = CMT_COMMIT;
            CMT_COMMIT: if (cmt_idx == LAST_IDX) cmt_next = CMT_WAIT;
            default:    cmt_next = CMT_WAIT;
        endcase
    end

    // Per-bin merge: new height wins only where it exceeds the decayed one.
    always_comb begin
        fresh   = use_new ? shadow[cmt_idx] : '0;
        decayed = sat_sub(disp[cmt_idx], DECAY_H);
        merged  = (fresh > decayed) ? fresh : decayed;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ing_state   <= ING_IDLE;
            exp_idx     <= '0;
            cmt_state   <= CMT_WAIT;
            cmt_idx     <= '0;
            use_new     <= 1'b0;
            commit_done <= 1'b0;
            err_seq     <= 1'b0;
        end else begin
            ing_state   <= ing_next;
            exp_idx     <= exp_next;
            cmt_state   <= cmt_next;
            cmt_idx     <= (cmt_state == CMT_COMMIT) ? cmt_idx + 1'b1 : '0;
            if ((cmt_state == CMT_WAIT) && vblank_start) begin
                use_new <= (ing_state == ING_FULL);
            end
            commit_done <= commit_last;
            err_seq     <= seq_err;
        end
    end

    // NOTE: both tables must read as zero straight after reset, so they are
    // flop arrays with a reset loop rather than an unreset RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                disp[i]   <= '0;
                shadow[i] <= '0;
            end
            rd_height <= '0;
        end else begin
            if (shadow_we) begin
                shadow[in_idx] <= conv_height;
            end
            if (cmt_state == CMT_COMMIT) begin
                disp[cmt_idx] <= merged;
            end
            // Reads see the table as it was before this edge's commit write.
            rd_height <= disp[rd_idx];
        end
    end

endmodule

// File: tb/tb_bar_update_scheduler.sv
// Self-checking bench for bar_update_scheduler with a reference model and
// expected-value queues for beats, commits and reads.
module tb_bar_update_scheduler;
    import vis_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [IDX_W-1:0]    in_idx;
    logic [MAG_W-1:0]    in_mag;
    logic                vblank_start;
    logic [IDX_W-1:0]    rd_idx;
    logic [HEIGHT_W-1:0] rd_height;
    logic                commit_done;
    logic                err_seq;

    bar_update_scheduler #(
        .DECAY (4),
        .SHIFT (14),
        .H_MAX (480)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_idx       (in_idx),
        .in_mag       (in_mag),
        .vblank_start (vblank_start),
        .rd_idx       (rd_idx),
        .rd_height    (rd_height),
        .commit_done  (commit_done),
        .err_seq      (err_seq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int rd_q[$];
    int err_q[$];
    int lat_q[$];

    // Reference model
    int m_disp   [NUM_BINS];
    int m_shadow [NUM_BINS];
    int m_exp;
    bit m_full;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int conv(input logic [MAG_W-1:0] m);
        int v;
        if (m[MAG_W-1]) return 0;
        v = int'(m >> 14);
        return (v > 480) ? 480 : v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_BINS; i++) begin
            m_disp[i]   = 0;
            m_shadow[i] = 0;
        end
        m_exp  = 0;
        m_full = 1'b0;
    endfunction

    // Returns 1 when the beat is expected to raise err_seq.
    function automatic int model_ingest(input int idx, input logic [MAG_W-1:0] mag);
        if (idx == m_exp || idx == 0) begin
            m_shadow[idx] = conv(mag);
            if (idx == 15) begin
                m_full = 1'b1;
                m_exp  = 0;
            end else begin
                m_exp = idx + 1;
            end
            return 0;
        end
        m_exp = 0;
        return 1;
    endfunction

    function automatic void model_commit();
        int f, d;
        for (int k = 0; k < NUM_BINS; k++) begin
            f = m_full ? m_shadow[k] : 0;
            d = (m_disp[k] > 4) ? m_disp[k] - 4 : 0;
            m_disp[k] = (f > d) ? f : d;
        end
        if (m_full) begin
            m_full = 1'b0;
            m_exp  = 0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int idx, input logic [MAG_W-1:0] mag);
        int n = 0;
        in_valid = 1'b1;
        in_idx   = IDX_W'(idx);
        in_mag   = mag;
        while (!in_ready && n < 64) begin
            tick();
            n++;
        end
        check("beat_ready_wait", n, 0);
        err_q.push_back(model_ingest(idx, mag));
        tick();
        in_valid = 1'b0;
        check($sformatf("err_seq_idx%0d", idx), err_seq, err_q.pop_front());
    endtask

    task automatic send_frame(input bit rand_mag);
        for (int i = 0; i < NUM_BINS; i++) begin
            send_beat(i, rand_mag ? MAG_W'($urandom_range(0, 24'hFFFFFF))
                                  : MAG_W'(i * 65536));
        end
    endtask

    // Pulses vblank_start and waits for commit_done; optional second pulse
    // mid-commit must be ignored.
    task automatic do_commit(input bit mid_vblank);
        int n = 0;
        int extra = 0;
        model_commit();
        lat_q.push_back(16);
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        while (!commit_done && n < 40) begin
            vblank_start = (mid_vblank && n == 4);
            tick();
            n++;
        end
        vblank_start = 1'b0;
        check("commit_latency", n, lat_q.pop_front());
        check("in_ready_at_done", in_ready, 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (commit_done) extra++;
        end
        check("no_extra_commit", extra, 0);
    endtask

    task automatic read_exp(input int idx, input int expected);
        rd_idx = IDX_W'(idx);
        rd_q.push_back(expected);
        tick();
        check($sformatf("rd_height[%0d]", idx), rd_height, rd_q.pop_front());
    endtask

    task automatic read_all();
        for (int i = 0; i < NUM_BINS; i++) read_exp(i, m_disp[i]);
    endtask

    initial begin
        int n;
        int early;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_idx       = '0;
        in_mag       = '0;
        vblank_start = 1'b0;
        rd_idx       = '0;
        model_reset();
        #12;
        check("reset_in_ready", in_ready, 1);
        check("reset_commit_done", commit_done, 0);
        check("reset_err_seq", err_seq, 0);
        check("reset_rd_height", rd_height, 0);
        tick();
        rst = 1'b0;
        tick();

        // Ramp frame: heights 4*i
        send_frame(1'b0);
        check("full_in_ready", in_ready, 0);
        do_commit(1'b0);
        read_exp(5, 20);
        read_exp(15, 60);
        read_all();

        // Two decay-only frames
        do_commit(1'b0);
        read_exp(5, 16);
        read_exp(0, 0);
        read_exp(1, 0);
        do_commit(1'b0);
        read_exp(5, 12);
        read_exp(1, 0);

        // Saturation and negative magnitude
        send_beat(0, 24'h7FFFFF);
        send_beat(1, 24'h800000);
        for (int i = 2; i < NUM_BINS; i++) send_beat(i, MAG_W'(i * 100000));
        do_commit(1'b0);
        read_exp(0, 480);
        read_exp(1, 0);
        read_all();

        // Sequence error then a clean frame
        send_beat(0, 24'h010000);
        send_beat(1, 24'h020000);
        send_beat(2, 24'h030000);
        send_beat(5, 24'h040000);
        send_frame(1'b1);
        do_commit(1'b0);
        read_all();

        // Restart via idx 0 mid-frame, decay-only commit while collecting
        for (int i = 0; i < 6; i++) send_beat(i, 24'h100000);
        for (int i = 0; i < 8; i++) send_beat(i, MAG_W'($urandom_range(0, 24'h7FFFFF)));
        do_commit(1'b0);
        for (int i = 8; i < NUM_BINS; i++) send_beat(i, MAG_W'($urandom_range(0, 24'h7FFFFF)));
        do_commit(1'b0);
        read_all();

        // Backpressure: beat held across a commit is taken after commit_done
        send_frame(1'b1);
        in_valid = 1'b1;
        in_idx   = '0;
        in_mag   = 24'h050000;
        check("held_in_ready_full", in_ready, 0);
        model_commit();
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        n = 0;
        early = 0;
        while (!commit_done && n < 40) begin
            if (in_ready) early++;
            tick();
            n++;
        end
        check("held_commit_latency", n, 16);
        check("held_ready_before_done", early, 0);
        check("held_ready_with_done", in_ready, 1);
        err_q.push_back(model_ingest(0, 24'h050000));
        tick();
        in_valid = 1'b0;
        check("held_err_seq", err_seq, err_q.pop_front());
        for (int i = 1; i < NUM_BINS; i++) send_beat(i, MAG_W'(i * 40000));
        do_commit(1'b0);
        read_all();

        // vblank_start during a decay-only commit is ignored
        do_commit(1'b1);
        read_all();

        // Reset in the middle of a commit
        send_frame(1'b0);
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        #2;
        check("midreset_rd_height", rd_height, 0);
        check("midreset_commit_done", commit_done, 0);
        check("midreset_in_ready", in_ready, 1);
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (commit_done) n++;
        end
        check("midreset_no_done", n, 0);
        check("midreset_ready_after", in_ready, 1);
        read_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
